// File: rtl/tcb_mem_sub.sv
// TCB subordinate backed by a word-organised memory, with programmable wait
// states before ready and a fixed response latency of DLY cycles.
module tcb_mem_sub #(
    parameter int AW    = 32,
    parameter int DW    = 32,
    parameter int SW    = 8,
    parameter int DLY   = 1,
    parameter int DEPTH = 1024,
    parameter int WAIT  = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tcb_vld,
    input  logic                tcb_wen,
    input  logic [DW/SW-1:0]    tcb_ben,
    input  logic [AW-1:0]       tcb_adr,
    input  logic [DW-1:0]       tcb_wdt,
    output logic [DW-1:0]       tcb_rdt,
    output logic                tcb_err,
    output logic                tcb_rdy
);

    localparam int BW = DW / SW;
    localparam int LB = $clog2(BW);
    localparam int IW = $clog2(DEPTH);

    logic [3:0]    cnt;
    logic          xfer;
    logic          err_req;
    logic [IW-1:0] idx;
    logic [DW-1:0] mem [DEPTH];
    logic          req_ren;
    logic          req_err;
    logic [DW-1:0] req_dat;

    assign tcb_rdy = rst & (cnt == 4'(WAIT));
    assign xfer    = tcb_vld & tcb_rdy;
    assign idx     = tcb_adr[LB +: IW];

    // Anything beyond the memory or not word aligned is answered with an error.
    assign err_req = ((tcb_adr >> (LB + IW)) != '0) || ((tcb_adr & AW'(BW - 1)) != '0);

    assign req_ren = xfer & ~tcb_wen;
    assign req_err = xfer & err_req;
    assign req_dat = err_req ? '0 : mem[idx];

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
        end else if (tcb_vld && !tcb_rdy) begin
            cnt <= cnt + 4'd1;
        end else begin
            cnt <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (xfer && tcb_wen && !err_req) begin
            for (int i = 0; i < BW; i++) begin
                if (tcb_ben[i]) begin
                    mem[idx][i*SW +: SW] <= tcb_wdt[i*SW +: SW];
                end
            end
        end
    end

    if (DLY == 0) begin : g_comb
        assign tcb_rdt = req_ren ? req_dat : '0;
        assign tcb_err = req_err;
    end else begin : g_pipe
        logic          tap_ren;
        logic          tap_err;
        logic [DW-1:0] tap_dat;
        logic          err_q;
        logic [DW-1:0] rdt_q;

        // The last of the DLY stages is the output register; earlier stages only shift.
        if (DLY == 1) begin : g_direct
            assign tap_ren = req_ren;
            assign tap_err = req_err;
            assign tap_dat = req_dat;
        end else begin : g_shift
            logic [DLY-2:0] sh_ren;
            logic [DLY-2:0] sh_err;
            logic [DW-1:0]  sh_dat [DLY-1];

            always_ff @(posedge clk) begin
                if (!rst) begin
                    sh_ren <= '0;
                    sh_err <= '0;
                    for (int k = 0; k < DLY-1; k++) begin
                        sh_dat[k] <= '0;
                    end
                end else begin
                    sh_ren[0] <= req_ren;
                    sh_err[0] <= req_err;
                    sh_dat[0] <= req_dat;
                    for (int k = 1; k < DLY-1; k++) begin
                        sh_ren[k] <= sh_ren[k-1];
                        sh_err[k] <= sh_err[k-1];
                        sh_dat[k] <= sh_dat[k-1];
                    end
                end
            end

            assign tap_ren = sh_ren[DLY-2];
            assign tap_err = sh_err[DLY-2];
            assign tap_dat = sh_dat[DLY-2];
        end

        // Read data is held between read responses; error is per-cycle.
        always_ff @(posedge clk) begin
            if (!rst) begin
                err_q <= 1'b0;
                rdt_q <= '0;
            end else begin
                err_q <= tap_err;
                if (tap_ren) begin
                    rdt_q <= tap_dat;
                end
            end
        end

        assign tcb_rdt = rdt_q;
        assign tcb_err = err_q;
    end

endmodule

// File: tb/tb_tcb_mem_sub.sv
// Bench for tcb_mem_sub: several parameter sets share one request stream and are
// checked every cycle against a timeline model of memory, waits and latency.
module tb_tcb_mem_sub;

    localparam int N     = 5;
    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int BW    = 4;
    localparam int DEPTH = 1024;
    localparam int DLY_C  [N] = '{1, 2, 1, 3, 0};
    localparam int WAIT_C [N] = '{0, 0, 3, 0, 1};

    logic          clk = 1'b0;
    logic          rst;
    logic          vld;
    logic          wen;
    logic [BW-1:0] ben;
    logic [AW-1:0] adr;
    logic [DW-1:0] wdt;
    logic [DW-1:0] rdt [N];
    logic          err [N];
    logic          rdy [N];

    int ncmp;
    int nfail;
    int cyc;
    bit armed;

    int        cnt_m   [N];
    bit [31:0] mem_m   [N][DEPTH];
    bit        hist_ren[N][8];
    bit        hist_err[N][8];
    bit [31:0] hist_dat[N][8];
    bit [31:0] exp_rdt [N];

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        tcb_mem_sub #(
            .AW(AW), .DW(DW), .SW(8), .DLY(DLY_C[g]), .DEPTH(DEPTH), .WAIT(WAIT_C[g])
        ) dut (
            .clk(clk),
            .rst(rst),
            .tcb_vld(vld),
            .tcb_wen(wen),
            .tcb_ben(ben),
            .tcb_adr(adr),
            .tcb_wdt(wdt),
            .tcb_rdt(rdt[g]),
            .tcb_err(err[g]),
            .tcb_rdy(rdy[g])
        );
    end

    task automatic check(input string tag, input int c, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s[%0d]: observed %h expected %h", tag, c, obs, exp);
        end
    endtask

    // One clock cycle: compare outputs with the model, then apply the edge to the model.
    task automatic step();
        bit        xf  [N];
        bit        rn  [N];
        bit        er  [N];
        bit        erdy[N];
        bit [31:0] rd  [N];
        bit        ereq;
        int        idx;
        int        slot;
        bit [31:0] e_rdt;
        bit        e_err;
        #1;
        ereq = (adr >= DEPTH * BW) || (adr % BW != 0);
        idx  = int'((adr / BW) % DEPTH);
        for (int c = 0; c < N; c++) begin
            erdy[c] = rst && (cnt_m[c] == WAIT_C[c]);
            xf[c]   = vld && erdy[c];
            rn[c]   = xf[c] && !wen;
            er[c]   = xf[c] && ereq;
            rd[c]   = ereq ? 32'h0 : mem_m[c][idx];
            if (DLY_C[c] == 0) begin
                e_rdt = rn[c] ? rd[c] : 32'h0;
                e_err = er[c];
            end else begin
                slot = (cyc - DLY_C[c]) % 8;
                if (cyc >= DLY_C[c] && hist_ren[c][slot]) exp_rdt[c] = hist_dat[c][slot];
                e_rdt = exp_rdt[c];
                e_err = (cyc >= DLY_C[c]) ? hist_err[c][slot] : 1'b0;
            end
            if (armed) begin
                check("rdy", c, {31'b0, rdy[c]}, {31'b0, erdy[c]});
                check("rdt", c, rdt[c], e_rdt);
                check("err", c, {31'b0, err[c]}, {31'b0, e_err});
            end
        end
        @(posedge clk);
        for (int c = 0; c < N; c++) begin
            if (!rst) begin
                cnt_m[c]   = 0;
                exp_rdt[c] = 32'h0;
                for (int k = 0; k < 8; k++) begin
                    hist_ren[c][k] = 1'b0;
                    hist_err[c][k] = 1'b0;
                end
            end else begin
                slot = cyc % 8;
                hist_ren[c][slot] = rn[c];
                hist_err[c][slot] = er[c];
                hist_dat[c][slot] = rd[c];
                if (xf[c] && wen && !ereq) begin
                    for (int b = 0; b < BW; b++) begin
                        if (ben[b]) mem_m[c][idx][8*b +: 8] = wdt[8*b +: 8];
                    end
                end
                cnt_m[c] = (vld && !erdy[c]) ? cnt_m[c] + 1 : 0;
            end
        end
        if (!rst) armed = 1'b1;
        cyc++;
        @(negedge clk);
    endtask

    task automatic req(input bit v, input bit w, input logic [3:0] b, input logic [31:0] a,
                       input logic [31:0] d, input int hold);
        vld = v; wen = w; ben = b; adr = a; wdt = d;
        repeat (hold) step();
    endtask

    initial begin
        $display("[TB] tcb_mem_sub bench, %0d configurations", N);
        ncmp = 0; nfail = 0; cyc = 0; armed = 1'b0;
        rst = 1'b0; vld = 1'b0; wen = 1'b0; ben = '0; adr = '0; wdt = '0;
        for (int c = 0; c < N; c++) begin
            cnt_m[c] = 0;
            exp_rdt[c] = 32'h0;
        end
        @(negedge clk);
        repeat (2) step();
        rst = 1'b1;

        // Fill a small working set so every later read has defined contents.
        for (int i = 0; i < 16; i++) req(1, 1, 4'hF, 32'(i * 4), $urandom, 4);
        req(0, 0, 4'h0, 32'h0, 32'h0, 1);

        req(1, 1, 4'hF, 32'h10, 32'hDEADBEEF, 1);
        req(1, 0, 4'hF, 32'h10, 32'h0, 1);
        vld = 1'b0;
        #1;
        check("beef_rdt", 0, rdt[0], 32'hDEADBEEF);
        check("beef_err", 0, {31'b0, err[0]}, 32'h0);
        req(0, 0, 4'h0, 32'h0, 32'h0, 3);

        req(1, 1, 4'hF, 32'h20, 32'h11223344, 4);
        req(1, 1, 4'h5, 32'h20, 32'hAABBCCDD, 4);
        req(1, 0, 4'hF, 32'h20, 32'h0, 1);
        vld = 1'b0;
        #1;
        check("ben_rdt", 0, rdt[0], 32'h11BB33DD);
        req(0, 0, 4'h0, 32'h0, 32'h0, 3);

        req(1, 0, 4'hF, 32'h1000, 32'h0, 1);
        vld = 1'b0;
        #1;
        check("oor_err", 0, {31'b0, err[0]}, 32'h1);
        check("oor_rdt", 0, rdt[0], 32'h0);
        req(1, 1, 4'hF, 32'h2, 32'h5A5A5A5A, 4);
        req(1, 0, 4'hF, 32'h0, 32'h0, 4);
        req(0, 0, 4'h0, 32'h0, 32'h0, 4);

        // Held read on the WAIT=3 instance: ready only on the fourth cycle.
        vld = 1'b1; wen = 1'b0; ben = 4'hF; adr = 32'h10;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("wait_rdy", 2, {31'b0, rdy[2]}, {31'b0, (i == 3)});
            step();
        end
        req(0, 0, 4'h0, 32'h0, 32'h0, 4);

        req(1, 0, 4'hF, 32'h0, 32'h0, 1);
        req(1, 0, 4'hF, 32'h4, 32'h0, 1);
        req(1, 0, 4'hF, 32'h8, 32'h0, 1);
        req(0, 0, 4'h0, 32'h0, 32'h0, 5);

        req(1, 0, 4'hF, 32'h10, 32'h0, 1);
        vld = 1'b0;
        rst = 1'b0;
        step();
        rst = 1'b1;
        req(0, 0, 4'h0, 32'h0, 32'h0, 5);
        req(1, 0, 4'hF, 32'h10, 32'h0, 1);
        req(0, 0, 4'h0, 32'h0, 32'h0, 4);

        for (int n = 0; n < 300; n++) begin
            int word;
            word = $urandom_range(0, 15);
            case ($urandom_range(0, 6))
                0:       adr = 32'h1000 + 32'($urandom_range(0, 4000) * 4);
                1:       adr = $urandom | 32'h8000_0000;
                2:       adr = 32'(word * 4 + $urandom_range(1, 3));
                default: adr = 32'(word * 4);
            endcase
            vld = ($urandom_range(0, 4) != 0);
            wen = $urandom_range(0, 1) == 1;
            ben = 4'($urandom);
            wdt = $urandom;
            if ($urandom_range(0, 39) == 0) begin
                rst = 1'b0;
                step();
                rst = 1'b1;
            end
            repeat ($urandom_range(1, 5)) step();
        end
        req(0, 0, 4'h0, 32'h0, 32'h0, 5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule

// File: doc/tcb_mem_sub.md
Name: tcb_mem_sub

Overview:
TCB subordinate (responder) terminating a TCB bus in a synchronous word-organised memory. It sits at the far end of a TCB chain, after managers and any register slices. It accepts requests under the vld/rdy handshake and inserts a programmable number of wait states. It returns read data and error status with a fixed response latency DLY, so it can serve as both a functional memory and a verification target for TCB managers.

Parameters:
AW, 32, address width in bits (byte address)
DW, 32, data width in bits
SW, 8, byte (select) width; BW = DW/SW byte enables
DLY, 1, response latency in cycles after the transfer cycle; legal range 0..4
DEPTH, 1024, memory size in words; must be a power of 2
WAIT, 0, wait states before rdy per transfer; legal range 0..15

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  reset, synchronous, active-low (reset when 0)
tcb_vld  input  1  request valid
tcb_wen  input  1  write enable (1 = write, 0 = read)
tcb_ben  input  BW  byte enables
tcb_adr  input  AW  byte address
tcb_wdt  input  DW  write data
tcb_rdt  output  DW  read data, valid DLY cycles after a read transfer
tcb_err  output  1  error response, valid DLY cycles after any transfer
tcb_rdy  output  1  ready; a transfer occurs on a cycle with tcb_vld & tcb_rdy

Behaviour:
- Reset (rst=0 at a clock edge): wait counter=0; response pipeline cleared; tcb_rdt=0, tcb_err=0; tcb_rdy=0 while rst=0. Memory contents are not reset.
- Wait counter cnt (4 bit):
  - tcb_rdy = rst & (cnt == WAIT), combinational.
  - If tcb_vld & ~tcb_rdy: cnt increments.
  - On a transfer, or when tcb_vld=0: cnt returns to 0.
  - WAIT=0 gives tcb_rdy=1 every cycle out of reset, so back-to-back transfers run at 1 per cycle.
  - If vld drops during a wait (protocol violation by the manager), the counter resets. No transfer occurs.
- Address decode:
  - word index = tcb_adr[log2(BW) +: log2(DEPTH)].
  - err_req = 1 if tcb_adr >= DEPTH*BW (out of range), or if tcb_adr[log2(BW)-1:0] != 0 (misaligned).
- Write transfer, err_req=0: on the transfer edge, each byte i with tcb_ben[i]=1 takes tcb_wdt byte i. Other bytes are unchanged.
- Write transfer, err_req=1: memory is untouched.
- Read transfer: samples the full word at the addressed index, using memory state before this edge. tcb_ben does not mask read data. A read in the cycle after a write to the same word returns the new data.
- Erroring read: returns tcb_rdt=0.
- Response pipeline, DLY>=1:
  - DLY-stage shift of {ren, err, data}.
  - The output stage updates tcb_err on every transfer.
  - The output stage updates tcb_rdt only on read transfers; otherwise tcb_rdt holds its previous value.
  - tcb_err is 0 in cycles with no transfer response.
  - Pipeline advances every cycle, independent of tcb_rdy. Responses are in order with no reordering.
- DLY=0: tcb_rdt and tcb_err are combinational from the current request and memory (async read), qualified by the transfer. When there is no transfer, tcb_rdt=0 and tcb_err=0.
- Reset asserted mid-operation: all in-flight responses are discarded. No write happens on a reset edge.
- Simultaneous events: exactly one transfer per cycle, so there are no read/write conflicts.

Test Plan:
- DLY=1, WAIT=0: write adr 0x10, wdt 0xDEADBEEF, ben 0xF. Next cycle read 0x10 -> tcb_rdy=1 both cycles; tcb_rdt=0xDEADBEEF, tcb_err=0 one cycle after the read transfer.
- Byte enables: write 0x11223344 to 0x20 with ben 0xF, then write 0xAABBCCDD with ben 0x5, then read 0x20 -> 0x11BB33DD.
- WAIT=3: hold vld with a read of 0x10 -> tcb_rdy low for 3 cycles, high on cycle 4, then low again for the next request. Data arrives DLY cycles after cycle 4.
- Errors, DEPTH=1024: read 0x1000 -> tcb_err=1, tcb_rdt=0. Write 0x0002 -> tcb_err=1 and the memory word at 0x0 is unchanged. A following valid read -> tcb_err=0.
- DLY=2, WAIT=0: reads of 0x0, 0x4, 0x8 on consecutive cycles -> the three data words appear in order on cycles +2, +3, +4 with no bubbles.
- Reset mid-operation, DLY=3: issue a read, then pull rst=0 one cycle later for 1 cycle -> tcb_rdt=0 and tcb_err=0 through the remaining cycles; no stale response emerges; memory still holds previously written data.
